cdb_sender_fifo: RTL and testbench
==================================

CDB_SENDER_FIFO -- requirements
Module: cdb_sender_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered result entries; SHALL be a power of two, 2 or greater.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 Port flush  input  1  synchronous pipeline flush.
REQ-005 Port exe_valid_i  input  1  execution unit presents a result this cycle.
REQ-006 Port exe_data_i  input  cdb_info_t  result payload (r_valid, rob_id, write-back data).
REQ-007 Port exe_ready_o  output  1  block accepts exe_data_i this cycle.
REQ-008 Port cdb_handshake  handshake_if.sender  -  CDB-facing port; block SHALL drive valid and data and SHALL sample ready.

Function
REQ-009 Storage SHALL be a circular buffer of DEPTH cdb_info_t entries, with read/write pointers of clog2(DEPTH) bits and an occupancy count of clog2(DEPTH)+1 bits.
REQ-010 exe_ready_o SHALL equal (count != DEPTH); no same-cycle bypass when full, even if a pop occurs.
REQ-011 Push SHALL occur when exe_valid_i && exe_ready_o && !flush && exe_data_i.r_valid.
REQ-012 An accepted beat with r_valid=0 SHALL be consumed and discarded, not enqueued.
REQ-013 cdb_handshake.valid SHALL equal (count != 0).
REQ-014 cdb_handshake.data SHALL equal mem[rd_ptr] when count != 0, and '0 when empty.
REQ-015 Pop SHALL occur when cdb_handshake.valid && cdb_handshake.ready && !flush.
REQ-016 Push latency SHALL be 1 cycle: an entry pushed in cycle N is first visible on cdb_handshake in cycle N+1; no empty-bypass.
REQ-017 Output SHALL be in-order; data SHALL hold stable while valid && !ready.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-019 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-020 A pop request when empty SHALL have no effect.
REQ-021 A push attempt when full SHALL have no effect; exe_ready_o=0 signals back-pressure to the execution unit.
REQ-022 ready from the CDB SHALL have no combinational path to exe_ready_o.
REQ-023 flush SHALL, on the next edge, set rd_ptr, wr_ptr and count to 0 and drop all entries.
REQ-024 During a flush cycle, push and pop SHALL both be suppressed.
REQ-025 Storage contents SHALL need no clearing on flush; the empty output SHALL be masked to '0 instead.

Reset
REQ-026 While rst_n=0, and immediately on its assertion, rd_ptr, wr_ptr and count SHALL be 0.
REQ-027 In the same condition, cdb_handshake.valid SHALL be 0, cdb_handshake.data SHALL be '0, and exe_ready_o SHALL be 1.
REQ-028 Reset asserted mid-operation SHALL discard all entries, with no partial pop or push.
REQ-029 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-030 Basic pass-through:
- Stimulus: push rob_id=5 (r_valid=1) in cycle 0, CDB ready=1.
- Response: valid=1 with rob_id=5 in cycle 1; valid=0 in cycle 2.
REQ-031 Fill and back-pressure:
- Stimulus: ready=0, push 5 entries rob_id 1..5 on consecutive cycles.
- Response: first 4 accepted; exe_ready_o=0 from cycle 4; rob_id 5 held by source.
- Then ready=1: output order is 1,2,3,4.
REQ-032 Wrap and simultaneous events:
- Stimulus: 10 entries streamed with ready toggling 1,0,1,0 while pushing every cycle the block accepts.
- Response: all 10 emerge in order; count never exceeds 4; pointers wrap with no loss or duplication.
REQ-033 Invalid drop:
- Stimulus: push r_valid=0 rob_id=7, then r_valid=1 rob_id=8.
- Response: only rob_id=8 appears on the CDB; count peaks at 1.
REQ-034 Flush:
- Stimulus: 3 entries queued, ready=0; assert flush for one cycle together with a push of rob_id=9.
- Response: next cycle valid=0, count=0, data='0; rob_id=9 never appears.
REQ-035 Async reset:
- Stimulus: 2 entries queued; drop rst_n between clock edges.
- Response: valid=0 and exe_ready_o=1 immediately, without waiting for a clock edge.
- After release: a new push appears 1 cycle later.

Source files
------------

// File: rtl/cdb_sender_fifo_if.sv
// Shared CDB result type and the valid/ready handshake bundle that carries it
// from a sender (execution-side buffer) to a receiver (the common data bus).
package cdb_pkg;
  localparam int ROB_ID_W = 5;
  localparam int XLEN     = 32;

  typedef struct packed {
    logic                r_valid;
    logic [ROB_ID_W-1:0] rob_id;
    logic [XLEN-1:0]     data;
  } cdb_info_t;
endpackage

// Handshake: a beat transfers on any rising edge where valid && ready; the
// sender keeps valid and data stable until that happens, and valid never
// depends combinationally on ready.
interface handshake_if;
  import cdb_pkg::*;

  logic      valid;
  logic      ready;
  cdb_info_t data;

  modport sender   (output valid, output data, input  ready);
  modport receiver (input  valid, input  data, output ready);
endinterface

// File: rtl/cdb_sender_fifo.sv
// Buffers execution-unit results and presents them in order on the CDB.
// Beats with r_valid=0 are accepted but dropped; flush empties the buffer.
module cdb_sender_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        exe_valid_i,
  input  cdb_info_t   exe_data_i,
  output logic        exe_ready_o,
  handshake_if.sender cdb_handshake
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cdb_sender_fifo: DEPTH must be a power of two and at least 2");
  end

  cdb_info_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  cdb_info_t rd_data;

  // Back-pressure looks only at the registered count, so CDB ready never
  // reaches exe_ready_o and a full buffer refuses even while it pops.
  always_comb begin
    full        = (count_q == FULL_CNT);
    empty       = (count_q == '0);
    exe_ready_o = !full;
    push        = exe_valid_i && !full && !flush && exe_data_i.r_valid;
    pop         = !empty && cdb_handshake.ready && !flush;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale slots are hidden by the empty mask below.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= exe_data_i;
  end

  always_comb begin
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
  end

  assign cdb_handshake.valid = !empty;
  assign cdb_handshake.data  = rd_data;

  a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= FULL_CNT);

  a_hold_while_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    (!empty && !cdb_handshake.ready && !flush) |=> (!empty && $stable(rd_data)));

endmodule

// File: tb/tb_cdb_sender_fifo.sv
// Directed and random stimulus for cdb_sender_fifo, checked against a queue
// model of the buffer's behaviour.
module tb_cdb_sender_fifo;
  import cdb_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = $bits(cdb_info_t);

  logic      clk = 1'b0;
  logic      rst_n = 1'b1;
  logic      flush;
  logic      exe_valid_i;
  cdb_info_t exe_data_i;
  logic      exe_ready_o;

  handshake_if hs ();

  cdb_sender_fifo #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .exe_valid_i   (exe_valid_i),
    .exe_data_i    (exe_data_i),
    .exe_ready_o   (exe_ready_o),
    .cdb_handshake (hs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]       exp_q [$];
  logic [ROB_ID_W-1:0] obs_q [$];
  logic                last_accept;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs against the model, advance the model.
  task automatic cycle(input logic ev, input logic rv, input logic [ROB_ID_W-1:0] rob,
                       input logic [XLEN-1:0] wd, input logic rdy, input logic fl,
                       input string tag);
    cdb_info_t     d;
    logic          e_ready;
    logic          e_valid;
    logic [DW-1:0] e_data;
    d.r_valid   = rv;
    d.rob_id    = rob;
    d.data      = wd;
    exe_valid_i = ev;
    exe_data_i  = d;
    hs.ready    = rdy;
    flush       = fl;
    #1;
    e_ready = (exp_q.size() != DEPTH);
    e_valid = (exp_q.size() != 0);
    e_data  = e_valid ? exp_q[0] : '0;
    check({tag, ".ready"}, 64'(exe_ready_o), 64'(e_ready));
    check({tag, ".valid"}, 64'(hs.valid), 64'(e_valid));
    check({tag, ".data"},  64'(hs.data), 64'(e_data));
    check({tag, ".count"}, 64'(dut.count_q), 64'(exp_q.size()));
    if (hs.valid && rdy && !fl) obs_q.push_back(hs.data.rob_id);
    last_accept = 1'b0;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (e_valid && rdy) void'(exp_q.pop_front());
      if (ev && e_ready) begin
        last_accept = 1'b1;
        if (rv) exp_q.push_back(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input string tag);
    cycle(1'b0, 1'b0, '0, '0, rdy, 1'b0, tag);
  endtask

  initial begin
    int next_id;
    logic rdy_t;

    flush       = 1'b0;
    exe_valid_i = 1'b0;
    exe_data_i  = '0;
    hs.ready    = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst.valid", 64'(hs.valid), 64'(0));
    check("rst.data",  64'(hs.data), 64'(0));
    check("rst.ready", 64'(exe_ready_o), 64'(1));
    check("rst.count", 64'(dut.count_q), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through; also the first push right after reset release
    cycle(1'b1, 1'b1, 5'd5, $urandom, 1'b1, 1'b0, "pass");
    idle(1'b1, "pass");
    idle(1'b1, "pass");

    // Fill and back-pressure, then drain in order
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b1, 5'(i), $urandom, 1'b0, 1'b0, "fill");
    obs_q.delete();
    repeat (5) idle(1'b1, "drain");
    check("drain.n", 64'(obs_q.size()), 64'(4));
    for (int i = 0; i < obs_q.size() && i < 4; i++) check("drain.order", 64'(obs_q[i]), 64'(i + 1));

    // Stream 10 entries with toggling ready; source holds a beat until accepted
    obs_q.delete();
    next_id = 1;
    rdy_t   = 1'b1;
    for (int i = 0; i < 200 && !(next_id > 10 && exp_q.size() == 0); i++) begin
      cycle(next_id <= 10, 1'b1, 5'(next_id), $urandom, rdy_t, 1'b0, "wrap");
      if (last_accept) next_id++;
      rdy_t = !rdy_t;
    end
    check("wrap.accepted", 64'(next_id - 1), 64'(10));
    check("wrap.n", 64'(obs_q.size()), 64'(10));
    for (int i = 0; i < obs_q.size() && i < 10; i++) check("wrap.order", 64'(obs_q[i]), 64'(i + 1));

    // Invalid beat is consumed but not queued
    obs_q.delete();
    cycle(1'b1, 1'b0, 5'd7, $urandom, 1'b0, 1'b0, "inval");
    cycle(1'b1, 1'b1, 5'd8, $urandom, 1'b0, 1'b0, "inval");
    idle(1'b0, "inval");
    repeat (2) idle(1'b1, "inval");
    check("inval.n", 64'(obs_q.size()), 64'(1));
    if (obs_q.size() > 0) check("inval.id", 64'(obs_q[0]), 64'(8));

    // Flush with a concurrent push
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b1, 5'(i + 20), $urandom, 1'b0, 1'b0, "flq");
    obs_q.delete();
    cycle(1'b1, 1'b1, 5'd9, $urandom, 1'b0, 1'b1, "flush");
    repeat (3) idle(1'b1, "postfl");
    check("postfl.n", 64'(obs_q.size()), 64'(0));

    // Asynchronous reset between edges with entries queued
    cycle(1'b1, 1'b1, 5'd10, $urandom, 1'b0, 1'b0, "arq");
    cycle(1'b1, 1'b1, 5'd11, $urandom, 1'b0, 1'b0, "arq");
    exe_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid", 64'(hs.valid), 64'(0));
    check("arst.ready", 64'(exe_ready_o), 64'(1));
    check("arst.data",  64'(hs.data), 64'(0));
    check("arst.count", 64'(dut.count_q), 64'(0));
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 5'd12, $urandom, 1'b1, 1'b0, "arel");
    idle(1'b1, "arel");
    idle(1'b1, "arel");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
            5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 31) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
